// File: rtl/tt_um_divider_pkg.sv
// rtl/tt_um_divider_pkg.sv - shared types and constants for the 8-bit restoring divider
package tt_um_divider_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions on the uio bus; prefixed so they cannot collide with the state names
    localparam int UIO_LOAD_A  = 0;
    localparam int UIO_LOAD_B  = 1;
    localparam int UIO_START   = 2;
    localparam int UIO_OUT_SEL = 3;
    localparam int UIO_BUSY    = 4;
    localparam int UIO_DONE    = 5;
    localparam int UIO_DIV0    = 6;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step (shift in next dividend bit, trial subtract)
module div_step
    import tt_um_divider_pkg::*;
(
    input  logic [WIDTH-1:0] r_in,
    input  logic             a_bit,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r_out,
    output logic             q_bit
);

    // Full partial remainder is kept to 9 bits so divisors above 128 still compare correctly
    logic [WIDTH:0] t;

    always_comb begin
        t     = {r_in, a_bit};
        q_bit = (t >= {1'b0, b});
        r_out = q_bit ? WIDTH'(t - {1'b0, b}) : t[WIDTH-1:0];
    end

endmodule

// File: rtl/tt_um_divider.sv
// rtl/tt_um_divider.sv - iterative 8-bit divider: operand registers, IDLE/RUN/DONE FSM and result mux
module tt_um_divider #(
    parameter int WIDTH = tt_um_divider_pkg::WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    import tt_um_divider_pkg::*;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     q_q;
    logic [WIDTH-1:0]     r_q;
    logic [CNT_W-1:0]     cnt;
    logic                 div0_q;
    logic                 busy;
    logic                 done;

    logic                 load_a;
    logic                 load_b;
    logic                 start;
    logic                 out_sel;
    logic                 any_load;
    logic                 b_zero;
    logic                 last_step;
    logic                 a_bit;
    logic [WIDTH-1:0]     r_step;
    logic                 q_step;
    logic                 unused_uio;

    assign load_a     = uio_in[UIO_LOAD_A];
    assign load_b     = uio_in[UIO_LOAD_B];
    assign start      = uio_in[UIO_START];
    assign out_sel    = uio_in[UIO_OUT_SEL];
    assign unused_uio = ^uio_in[7:4];

    assign any_load  = load_a | load_b;
    assign b_zero    = (b_q == '0);
    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign a_bit     = a_q[CNT_W'(WIDTH - 1) - cnt];

    div_step u_div_step (
        .r_in  (r_step_in()),
        .a_bit (a_bit),
        .b     (b_q),
        .r_out (r_step),
        .q_bit (q_step)
    );

    function automatic logic [WIDTH-1:0] r_step_in();
        return r_q;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    // Loads take priority over start; a zero divisor skips RUN entirely
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (any_load) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    state_nxt = b_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            q_q    <= '0;
            r_q    <= '0;
            cnt    <= '0;
            div0_q <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE, DONE: begin
                    if (load_a) begin
                        a_q <= ui_in;
                    end
                    if (load_b) begin
                        b_q <= ui_in;
                    end
                    if (any_load) begin
                        div0_q <= 1'b0;
                    end else if (start) begin
                        cnt <= '0;
                        if (b_zero) begin
                            q_q    <= '1;
                            r_q    <= a_q;
                            div0_q <= 1'b1;
                        end else begin
                            q_q    <= '0;
                            r_q    <= '0;
                            div0_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // Quotient bits arrive MSB first, so shifting left lands bit i at 7-i
                    q_q <= {q_q[WIDTH-2:0], q_step};
                    r_q <= r_step;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign uo_out  = out_sel ? r_q : q_q;
    assign uio_out = {1'b0, div0_q, done, busy, 4'b0000};
    assign uio_oe  = UIO_OE_MASK;

endmodule
